// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the generic GPIO bank.
// Holds the debounce counter sizing and the per-pin edge-pulse bundle.
package gpio_pkg;

    localparam int DEF_N_PINS          = 8;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // The counter only ever holds 0..D-1, so clog2(D) bits suffice; keep at least one bit.
    function automatic int cnt_width(input int d);
        return (clog2(d) < 1) ? 1 : clog2(d);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input pin: metastability synchroniser, debounce filter, and
// rise/fall pulse generation from the debounced level.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic  clock,
    input  logic  reset_n,
    input  logic  raw_i,
    output logic  level_o,
    output edge_t edge_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   st_q;
    logic                   st_d;
    logic                   st_dly_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign st_d = s;
        end else begin : g_filter
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Any sample agreeing with the stable level restarts the count.
            always_comb begin
                cnt_d = '0;
                st_d  = st_q;
                if (s != st_q) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        st_d = s;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Both level registers clear together so reset itself never looks like an edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            st_q     <= 1'b0;
            st_dly_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            st_dly_q <= st_q;
        end
    end

    assign level_o     = st_q;
    assign edge_o.rise = st_q & ~st_dly_q;
    assign edge_o.fall = ~st_q & st_dly_q;

endmodule

// File: rtl/generic_gpio_bank.sv
// N-pin bidirectional GPIO bank: registered output/enable driving the pads,
// per-pin filtered inputs, and sticky edge-pending flags with a combined interrupt.
module generic_gpio_bank
    import gpio_pkg::*;
#(
    parameter int N_PINS          = DEF_N_PINS,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic              clock,
    input  logic              reset_n,
    inout  wire  [N_PINS-1:0] pad,
    input  logic [N_PINS-1:0] o,
    input  logic [N_PINS-1:0] oe,
    input  logic [N_PINS-1:0] ie,
    output logic [N_PINS-1:0] i,
    output logic [N_PINS-1:0] io_oeb,
    input  logic [N_PINS-1:0] rise_en,
    input  logic [N_PINS-1:0] fall_en,
    input  logic [N_PINS-1:0] irq_clr,
    output logic [N_PINS-1:0] irq_pending,
    output logic              irq
);

    logic [N_PINS-1:0] o_q;
    logic [N_PINS-1:0] oe_q;
    logic [N_PINS-1:0] raw;
    logic [N_PINS-1:0] rise;
    logic [N_PINS-1:0] fall;
    logic [N_PINS-1:0] pending_q;
    logic [N_PINS-1:0] pending_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            o_q  <= '0;
            oe_q <= '0;
        end else begin
            o_q  <= o;
            oe_q <= oe;
        end
    end

    assign io_oeb = ~oe_q;

    genvar k;
    generate
        for (k = 0; k < N_PINS; k++) begin : g_pin
            edge_t pin_edge;

            assign pad[k] = oe_q[k] ? o_q[k] : 1'bz;
            // With ie low the pin reads as 0, so disabling a high input debounces as a fall.
            assign raw[k] = ie[k] & pad[k];

            gpio_debounce #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clock  (clock),
                .reset_n(reset_n),
                .raw_i  (raw[k]),
                .level_o(i[k]),
                .edge_o (pin_edge)
            );

            assign rise[k] = pin_edge.rise;
            assign fall[k] = pin_edge.fall;
        end
    endgenerate

    // A new edge on the same cycle as a clear keeps the flag set.
    always_comb begin
        pending_d = (pending_q & ~irq_clr) | (rise & rise_en) | (fall & fall_en);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign irq_pending = pending_q;
    assign irq         = |pending_q;

endmodule

// File: tb/tb_generic_gpio_bank.sv
// Directed bench for generic_gpio_bank with default parameters (8 pins, 2 sync, 4 debounce).
module tb_generic_gpio_bank;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] o, oe, ie, rise_en, fall_en, irq_clr;
    logic [7:0] i, io_oeb, irq_pending;
    logic       irq;
    wire  [7:0] pad;
    logic [7:0] drv_en, drv_val;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clock = ~clock;

    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_drv
            assign pad[k] = drv_en[k] ? drv_val[k] : 1'bz;
        end
    endgenerate

    generic_gpio_bank dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pad        (pad),
        .o          (o),
        .oe         (oe),
        .ie         (ie),
        .i          (i),
        .io_oeb     (io_oeb),
        .rise_en    (rise_en),
        .fall_en    (fall_en),
        .irq_clr    (irq_clr),
        .irq_pending(irq_pending),
        .irq        (irq)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; o = 8'hFF; oe = 8'hFF; ie = 8'h00;
        rise_en = 8'h00; fall_en = 8'h00; irq_clr = 8'h00;
        drv_en = 8'h00; drv_val = 8'h00;
        tick(3);
        check("rst_io_oeb", io_oeb, 8'hFF);
        check("rst_i", i, 8'h00);
        check("rst_pending", irq_pending, 8'h00);
        check("rst_irq", irq, 1'b0);

        // Output path: one register of latency
        reset_n = 1'b1; oe = 8'h0F; o = 8'h05;
        #1;
        check("out_oeb_before_edge", io_oeb, 8'hFF);
        tick(1);
        check("out_pad_lo", pad[3:0], 4'b0101);
        check("out_io_oeb", io_oeb, 8'hF0);
        o = 8'h0A;
        tick(1);
        check("out_pad_lo2", pad[3:0], 4'b1010);

        oe = 8'h00; o = 8'h00;
        tick(1);
        check("out_release", io_oeb, 8'hFF);
        drv_en = 8'h7F; drv_val = 8'h00; ie = 8'h7F;
        tick(8);
        check("in_idle", i, 8'h00);

        // Debounce latency SYNC+D = 6 edges
        drv_val[0] = 1'b1;
        tick(5);
        check("deb_rise_early", i, 8'h00);
        tick(1);
        check("deb_rise", i, 8'h01);
        drv_val[0] = 1'b0;
        tick(5);
        check("deb_fall_early", i, 8'h01);
        tick(1);
        check("deb_fall", i, 8'h00);
        drv_val[0] = 1'b1;
        tick(3);
        drv_val[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            check("deb_glitch", i, 8'h00);
        end

        // Rising-edge capture on pin 2, falling edge ignored
        rise_en = 8'h04;
        drv_val[2] = 1'b1;
        tick(6);
        check("edge_i_rise", i, 8'h04);
        check("edge_pend_before", irq_pending, 8'h00);
        tick(1);
        check("edge_pend", irq_pending, 8'h04);
        check("edge_irq", irq, 1'b1);
        drv_val[2] = 1'b0;
        tick(8);
        check("edge_i_fall", i, 8'h00);
        check("edge_pend_after_fall", irq_pending, 8'h04);

        // Clear racing a new rise: set wins, then clear alone empties
        drv_val[2] = 1'b1;
        tick(6);
        check("race_i", i, 8'h04);
        irq_clr = 8'h04;
        tick(1);
        check("race_pend", irq_pending, 8'h04);
        tick(1);
        check("clr_pend", irq_pending, 8'h00);
        check("clr_irq", irq, 1'b0);
        irq_clr = 8'h00;

        // Dropping ie on a high pin reads as a debounced fall
        fall_en = 8'h08;
        drv_val[3] = 1'b1;
        tick(6);
        check("ie_i_high", i, 8'h0C);
        check("ie_no_rise_pend", irq_pending, 8'h00);
        ie = 8'h77;
        tick(5);
        check("ie_i_hold", i, 8'h0C);
        tick(1);
        check("ie_i_fall", i, 8'h04);
        tick(1);
        check("ie_fall_pend", irq_pending, 8'h08);
        irq_clr = 8'h08;
        tick(1);
        irq_clr = 8'h00;
        check("ie_clr", irq_pending, 8'h00);
        ie = 8'h7F; drv_val = 8'h00; fall_en = 8'h00; rise_en = 8'h00;
        tick(8);
        check("idle_i", i, 8'h00);
        check("idle_pend", irq_pending, 8'h00);

        // Loopback: pin 7 driven by the bank and read back
        oe = 8'h80; o = 8'h80; ie = 8'hFF;
        tick(6);
        check("loop_early", i, 8'h00);
        check("loop_oeb", io_oeb, 8'h7F);
        tick(1);
        check("loop_i", i, 8'h80);
        o = 8'h00;
        tick(8);
        check("loop_low", i, 8'h00);

        // Reset in the middle of a debounce with a pending flag
        rise_en = 8'h02;
        drv_val[1] = 1'b1;
        tick(7);
        check("mid_pend", irq_pending, 8'h02);
        drv_val[1] = 1'b0;
        tick(4);
        check("mid_i_hold", i, 8'h02);
        reset_n = 1'b0;
        tick(1);
        check("mid_rst_i", i, 8'h00);
        check("mid_rst_pend", irq_pending, 8'h00);
        check("mid_rst_irq", irq, 1'b0);
        check("mid_rst_oeb", io_oeb, 8'hFF);
        reset_n = 1'b1; rise_en = 8'h00; drv_val[1] = 1'b1;
        tick(5);
        check("post_rst_early", i, 8'h00);
        tick(1);
        check("post_rst_i", i, 8'h02);
        tick(1);
        check("post_rst_pend", irq_pending, 8'h00);
        check("post_rst_irq", irq, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
